// File: rtl/meteor_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : meteor_field_ctrl
// Brief    : Falling-meteor field for the shooter game. Spawns meteors on the
//            top row, steps them down the 40x30 board, detects bullet hits,
//            keeps score / lives / game-over and drives a registered per-cell
//            draw flag for the VGA compositor.
// Revision : 1.0 - initial release
// ============================================================================
module meteor_field_ctrl #(
  parameter int c_GameWidth   = 40,
  parameter int c_GameHeight  = 30,
  parameter int c_NumMeteors  = 4,
  parameter int c_MeteorSpeed = 2500000,
  parameter int c_SpawnGap    = 8,
  parameter int c_Lives       = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_GameActive,
  input  logic       i_BullActive,
  input  logic [5:0] i_BullX,
  input  logic [5:0] i_BullY,
  input  logic [5:0] i_ColCountDiv,
  input  logic [5:0] i_RowCountDiv,
  output logic       o_DrawMeteor,
  output logic       o_Hit,
  output logic       o_Miss,
  output logic [7:0] o_Score,
  output logic [1:0] o_Lives,
  output logic       o_GameOver
);

  localparam logic [1:0] c_StIdle = 2'd0;
  localparam logic [1:0] c_StPlay = 2'd1;
  localparam logic [1:0] c_StOver = 2'd2;

  localparam int                 c_TickW    = (c_MeteorSpeed > 1) ? $clog2(c_MeteorSpeed) : 1;
  localparam logic [c_TickW-1:0] c_TickLast = c_TickW'(c_MeteorSpeed - 1);
  localparam int                 c_GapW     = (c_SpawnGap > 1) ? $clog2(c_SpawnGap) : 1;
  localparam logic [c_GapW-1:0]  c_GapLast  = c_GapW'(c_SpawnGap - 1);
  localparam logic [5:0]         c_Width6   = 6'(c_GameWidth);
  localparam logic [5:0]         c_LastRow  = 6'(c_GameHeight - 1);
  localparam logic [1:0]         c_Lives2   = 2'(c_Lives);

  logic [1:0]              r_State;
  logic [1:0]              w_NextState;
  logic [c_TickW-1:0]      r_TickCount;
  logic [c_GapW-1:0]       r_SpawnCount;
  logic [7:0]              r_Lfsr;
  logic [c_NumMeteors-1:0] r_Act;
  logic [5:0]              r_X [c_NumMeteors];
  logic [5:0]              r_Y [c_NumMeteors];
  logic                    r_Draw;
  logic                    r_Hit;
  logic                    r_Miss;
  logic [7:0]              r_Score;
  logic [1:0]              r_Lives;

  logic                    w_Play;
  logic                    w_Tick;
  logic                    w_SpawnNow;
  logic                    w_SpawnTaken;
  logic                    w_LfsrFb;
  logic [5:0]              w_LfsrLow;
  logic [5:0]              w_SpawnX;
  logic                    w_GameOver;
  logic [c_NumMeteors-1:0] w_Coll;
  logic [c_NumMeteors-1:0] w_MissSlot;
  logic [c_NumMeteors-1:0] w_Free;
  logic [c_NumMeteors-1:0] w_SpawnOh;
  logic [c_NumMeteors-1:0] w_DrawMatch;

  assign w_Play     = (r_State == c_StPlay);
  assign w_Tick     = w_Play && (r_TickCount == c_TickLast);
  assign w_SpawnNow = w_Tick && (r_SpawnCount == c_GapLast);
  assign w_LfsrFb   = r_Lfsr[7] ^ r_Lfsr[5] ^ r_Lfsr[4] ^ r_Lfsr[3];
  assign w_LfsrLow  = r_Lfsr[5:0];
  // Fold the 0..63 random value onto the 0..c_GameWidth-1 column range
  assign w_SpawnX   = (w_LfsrLow >= c_Width6) ? (w_LfsrLow - c_Width6) : w_LfsrLow;

  // Per-slot hit, bottom-exit, free and draw-match decode; a hit always
  // beats the tick so a struck meteor can never also count as a miss
  generate
    for (genvar gi = 0; gi < c_NumMeteors; gi++) begin : g_slot
      assign w_Coll[gi]      = w_Play && r_Act[gi] && i_BullActive &&
                               (r_X[gi] == i_BullX) && (r_Y[gi] == i_BullY);
      assign w_MissSlot[gi]  = w_Tick && r_Act[gi] && !w_Coll[gi] && (r_Y[gi] == c_LastRow);
      assign w_Free[gi]      = !r_Act[gi] || w_MissSlot[gi];
      assign w_DrawMatch[gi] = r_Act[gi] && (r_X[gi] == i_ColCountDiv) &&
                               (r_Y[gi] == i_RowCountDiv);
    end
  endgenerate

  // Spawn target: lowest-index slot that is free after this cycle's misses
  always_comb begin
    w_SpawnOh    = '0;
    w_SpawnTaken = 1'b0;
    for (int i = 0; i < c_NumMeteors; i++) begin
      if (w_Free[i] && !w_SpawnTaken) begin
        w_SpawnOh[i] = w_SpawnNow;
        w_SpawnTaken = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_State <= c_StIdle;
    else       r_State <= w_NextState;
  end

  // Next-state logic; OVER is entered one cycle after lives read zero
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      c_StIdle: if (i_GameActive) w_NextState = c_StPlay;
      c_StPlay: begin
        if (!i_GameActive)        w_NextState = c_StIdle;
        else if (r_Lives == 2'd0) w_NextState = c_StOver;
      end
      c_StOver: if (!i_GameActive) w_NextState = c_StIdle;
      default:  w_NextState = c_StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_GameOver = (r_State == c_StOver);
  end

  // Movement tick and spawn-gap counters: cleared in IDLE, frozen in OVER
  always_ff @(posedge i_Clk) begin
    if (i_Rst || r_State == c_StIdle) begin
      r_TickCount  <= '0;
      r_SpawnCount <= '0;
    end else if (w_Play) begin
      r_TickCount <= w_Tick ? '0 : r_TickCount + c_TickW'(1);
      if (w_Tick) r_SpawnCount <= (r_SpawnCount == c_GapLast) ? '0 : r_SpawnCount + c_GapW'(1);
    end
  end

  // Free-running random source, never reseeded by a game start
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_Lfsr <= 8'hA5;
    else       r_Lfsr <= {r_Lfsr[6:0], w_LfsrFb};
  end

  // Meteor slots: destroy on hit, fall on tick, leave at the bottom, spawn
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Act <= '0;
      for (int i = 0; i < c_NumMeteors; i++) begin
        r_X[i] <= '0;
        r_Y[i] <= '0;
      end
    end else if (r_State == c_StIdle || (w_Play && !i_GameActive)) begin
      r_Act <= '0;
    end else if (w_Play) begin
      for (int i = 0; i < c_NumMeteors; i++) begin
        if (w_Coll[i] || w_MissSlot[i]) r_Act[i] <= 1'b0;
        else if (w_Tick && r_Act[i])    r_Y[i]   <= r_Y[i] + 6'd1;
        if (w_SpawnOh[i]) begin
          r_Act[i] <= 1'b1;
          r_X[i]   <= w_SpawnX;
          r_Y[i]   <= 6'd0;
        end
      end
    end
  end

  // Draw flag, one clock behind the pixel counters; blanked once in IDLE
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_Draw <= 1'b0;
    else       r_Draw <= (w_NextState != c_StIdle) && (|w_DrawMatch);
  end

  // Hit/miss pulses, saturating score and lives bookkeeping
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Hit   <= 1'b0;
      r_Miss  <= 1'b0;
      r_Score <= 8'd0;
      r_Lives <= c_Lives2;
    end else begin
      r_Hit  <= |w_Coll;
      r_Miss <= |w_MissSlot;
      if (r_State == c_StIdle && i_GameActive) begin
        r_Score <= 8'd0;
        r_Lives <= c_Lives2;
      end else if (w_Play) begin
        if ((|w_Coll) && r_Score != 8'd255)  r_Score <= r_Score + 8'd1;
        if ((|w_MissSlot) && r_Lives != 2'd0) r_Lives <= r_Lives - 2'd1;
      end
    end
  end

  assign o_DrawMeteor = r_Draw;
  assign o_Hit        = r_Hit;
  assign o_Miss       = r_Miss;
  assign o_Score      = r_Score;
  assign o_Lives      = r_Lives;
  assign o_GameOver   = w_GameOver;

endmodule
`default_nettype wire

// File: tb/tb_meteor_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_meteor_field_ctrl
// Brief    : Self-checking bench for meteor_field_ctrl (speed 4, gap 2,
//            2 slots, 2 lives). Edge numbers are counted from the clock edge
//            that moves the block from IDLE into PLAY.
// Revision : 1.0 - initial release
// ============================================================================
module tb_meteor_field_ctrl;

  logic       clk = 1'b0;
  logic       rst, ga, ba;
  logic [5:0] bx, by, col, row;
  logic       o_DrawMeteor, o_Hit, o_Miss, o_GameOver;
  logic [7:0] o_Score;
  logic [1:0] o_Lives;

  always #5 clk = ~clk;

  meteor_field_ctrl #(
    .c_GameWidth(40), .c_GameHeight(30), .c_NumMeteors(2),
    .c_MeteorSpeed(4), .c_SpawnGap(2), .c_Lives(2)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_GameActive(ga), .i_BullActive(ba),
    .i_BullX(bx), .i_BullY(by), .i_ColCountDiv(col), .i_RowCountDiv(row),
    .o_DrawMeteor(o_DrawMeteor), .o_Hit(o_Hit), .o_Miss(o_Miss),
    .o_Score(o_Score), .o_Lives(o_Lives), .o_GameOver(o_GameOver)
  );

  // Reference random source: x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct { logic hit; logic [7:0] score; } hit_exp_t;
  hit_exp_t hit_q[$];

  int n_pass = 0;
  int n_total = 0;
  int ecount = 0;
  logic [5:0] x0, x1, x4, xs;

  function automatic logic [5:0] fold(input logic [7:0] l);
    logic [5:0] v;
    v = l[5:0];
    if (v >= 6'd40) v = v - 6'd40;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int e);
    while (ecount < e) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ga = 1'b0; ba = 1'b0; bx = '0; by = '0; col = '0; row = '0;
    step(); step();
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL rst_draw: got %b want 0", o_DrawMeteor); else n_pass++;
    n_total++; if (o_Hit !== 1'b0) $display("FAIL rst_hit: got %b want 0", o_Hit); else n_pass++;
    n_total++; if (o_Miss !== 1'b0) $display("FAIL rst_miss: got %b want 0", o_Miss); else n_pass++;
    n_total++; if (o_Score !== 8'd0) $display("FAIL rst_score: got %0d want 0", o_Score); else n_pass++;
    n_total++; if (o_Lives !== 2'd2) $display("FAIL rst_lives: got %0d want 2", o_Lives); else n_pass++;
    n_total++; if (o_GameOver !== 1'b0) $display("FAIL rst_over: got %b want 0", o_GameOver); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (o_Lives !== 2'd2) $display("FAIL idle_lives: got %0d want 2", o_Lives); else n_pass++;
  endtask

  task automatic test_spawn();
    ga = 1'b1;
    step();
    ecount = 0;
    run_to(7);
    x0 = fold(m_lfsr);
    col = x0; row = 6'd0;
    run_to(8);
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL draw_before_spawn: got %b want 0", o_DrawMeteor); else n_pass++;
    run_to(9);
    n_total++; if (o_DrawMeteor !== 1'b1) $display("FAIL draw_spawn x=%0d: got %b want 1", x0, o_DrawMeteor); else n_pass++;
    row = 6'd1;
    run_to(10);
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL draw_row1_early: got %b want 0", o_DrawMeteor); else n_pass++;
    run_to(13);
    n_total++; if (o_DrawMeteor !== 1'b1) $display("FAIL draw_row1_after_tick: got %b want 1", o_DrawMeteor); else n_pass++;
  endtask

  task automatic test_hit_inactive();
    ba = 1'b0; bx = x0; by = 6'd1;
    run_to(14);
    n_total++; if (o_Hit !== 1'b0) $display("FAIL inactive_hit: got %b want 0", o_Hit); else n_pass++;
    n_total++; if (o_Score !== 8'd0) $display("FAIL inactive_score: got %0d want 0", o_Score); else n_pass++;
    run_to(15);
    x1 = fold(m_lfsr);
    row = 6'd2;
    run_to(17);
    n_total++; if (o_DrawMeteor !== 1'b1) $display("FAIL still_falling: got %b want 1", o_DrawMeteor); else n_pass++;
  endtask

  task automatic test_hit();
    hit_exp_t e;
    ba = 1'b1; bx = x0; by = 6'd2;
    hit_q.push_back('{hit: 1'b1, score: 8'd1});
    run_to(18);
    e = hit_q.pop_front();
    n_total++; if (o_Hit !== e.hit) $display("FAIL hit_pulse: got %b want %b", o_Hit, e.hit); else n_pass++;
    n_total++; if (o_Score !== e.score) $display("FAIL hit_score: got %0d want %0d", o_Score, e.score); else n_pass++;
    ba = 1'b0;
    run_to(19);
    n_total++; if (o_Hit !== 1'b0) $display("FAIL hit_one_clock: got %b want 0", o_Hit); else n_pass++;
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL hit_slot_gone: got %b want 0", o_DrawMeteor); else n_pass++;
  endtask

  task automatic test_collide_tick();
    hit_exp_t e;
    run_to(23);
    ba = 1'b1; bx = x1; by = 6'd1;
    hit_q.push_back('{hit: 1'b1, score: 8'd2});
    run_to(24);
    e = hit_q.pop_front();
    n_total++; if (o_Hit !== e.hit) $display("FAIL tick_hit: got %b want %b", o_Hit, e.hit); else n_pass++;
    n_total++; if (o_Score !== e.score) $display("FAIL tick_score: got %0d want %0d", o_Score, e.score); else n_pass++;
    n_total++; if (o_Miss !== 1'b0) $display("FAIL tick_miss: got %b want 0", o_Miss); else n_pass++;
    ba = 1'b0; col = x1; row = 6'd2;
    run_to(25);
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL tick_not_moved: got %b want 0", o_DrawMeteor); else n_pass++;
  endtask

  task automatic test_miss();
    run_to(143);
    n_total++; if (o_Miss !== 1'b0) $display("FAIL miss_early: got %b want 0", o_Miss); else n_pass++;
    x4 = fold(m_lfsr);
    run_to(144);
    n_total++; if (o_Miss !== 1'b1) $display("FAIL miss1_pulse: got %b want 1", o_Miss); else n_pass++;
    n_total++; if (o_Lives !== 2'd1) $display("FAIL miss1_lives: got %0d want 1", o_Lives); else n_pass++;
    run_to(145);
    n_total++; if (o_Miss !== 1'b0) $display("FAIL miss1_width: got %b want 0", o_Miss); else n_pass++;
    run_to(152);
    n_total++; if (o_Miss !== 1'b1) $display("FAIL miss2_pulse: got %b want 1", o_Miss); else n_pass++;
    n_total++; if (o_Lives !== 2'd0) $display("FAIL miss2_lives: got %0d want 0", o_Lives); else n_pass++;
    n_total++; if (o_GameOver !== 1'b0) $display("FAIL over_early: got %b want 0", o_GameOver); else n_pass++;
    run_to(153);
    n_total++; if (o_GameOver !== 1'b1) $display("FAIL over_set: got %b want 1", o_GameOver); else n_pass++;
    col = x4; row = 6'd2;
    run_to(170);
    n_total++; if (o_DrawMeteor !== 1'b1) $display("FAIL over_frozen_draw: got %b want 1", o_DrawMeteor); else n_pass++;
    n_total++; if (o_Lives !== 2'd0) $display("FAIL over_lives: got %0d want 0", o_Lives); else n_pass++;
    ga = 1'b0;
    run_to(172);
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL idle_draw_off: got %b want 0", o_DrawMeteor); else n_pass++;
    n_total++; if (o_GameOver !== 1'b0) $display("FAIL idle_over_clr: got %b want 0", o_GameOver); else n_pass++;
    n_total++; if (o_Score !== 8'd2) $display("FAIL idle_score_held: got %0d want 2", o_Score); else n_pass++;
  endtask

  task automatic test_saturate();
    hit_exp_t e;
    ga = 1'b1;
    step();
    ecount = 0;
    run_to(7);
    for (int n = 0; n < 256; n++) begin
      xs = fold(m_lfsr);
      step();
      ba = 1'b1; bx = xs; by = 6'd0;
      hit_q.push_back('{hit: 1'b1, score: (n >= 254) ? 8'd255 : 8'(n + 1)});
      step();
      e = hit_q.pop_front();
      n_total++; if (o_Hit !== e.hit) $display("FAIL sat_hit[%0d]: got %b want %b", n, o_Hit, e.hit); else n_pass++;
      n_total++; if (o_Score !== e.score) $display("FAIL sat_score[%0d]: got %0d want %0d", n, o_Score, e.score); else n_pass++;
      ba = 1'b0;
      repeat (6) step();
    end
  endtask

  task automatic test_reset_mid();
    xs = fold(m_lfsr);
    step();
    ba = 1'b1; bx = xs; by = 6'd0; col = xs; row = 6'd0; rst = 1'b1;
    step();
    n_total++; if (o_DrawMeteor !== 1'b0) $display("FAIL mid_rst_draw: got %b want 0", o_DrawMeteor); else n_pass++;
    n_total++; if (o_Hit !== 1'b0) $display("FAIL mid_rst_hit: got %b want 0", o_Hit); else n_pass++;
    n_total++; if (o_Miss !== 1'b0) $display("FAIL mid_rst_miss: got %b want 0", o_Miss); else n_pass++;
    n_total++; if (o_Score !== 8'd0) $display("FAIL mid_rst_score: got %0d want 0", o_Score); else n_pass++;
    n_total++; if (o_Lives !== 2'd2) $display("FAIL mid_rst_lives: got %0d want 2", o_Lives); else n_pass++;
    n_total++; if (o_GameOver !== 1'b0) $display("FAIL mid_rst_over: got %b want 0", o_GameOver); else n_pass++;
    rst = 1'b0; ba = 1'b0; ga = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_hit_inactive();
    test_hit();
    test_collide_tick();
    test_miss();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
